// File: rtl/bicubic_window_gen.sv
// bicubic_window_gen
//   Builds the 4-tap horizontal window {p[i-1], p[i], p[i+1], p[i+2]} from a
//   raster row of 8-bit pixels and emits each window SCALE times, once per
//   phase. Both row ends are padded. By default the padding replicates the
//   edge pixel. Define BICUBIC_MIRROR_EDGE_EN to mirror about the edge pixel
//   instead. Handshake timing and beat counts are the same in both builds.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   in_pix     input pixel            (valid/ready stream in)
//   in_valid   in_pix valid
//   in_ready   block accepts in_pix this cycle
//   out_0..3   window taps p[i-1], p[i], p[i+1], p[i+2]
//   out_phase  phase index 0..SCALE-1
//   out_valid  window and phase valid  (valid/ready stream out)
//   out_ready  downstream accepts the window
//   out_last   final beat of a row (i = LINE_W-1, phase = SCALE-1)
module bicubic_window_gen #(
   parameter int LINE_W  = 64,
   parameter int SCALE   = 4,
   parameter int PHASE_W = 2,
   parameter int CNT_W   = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         in_pix,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [7:0]         out_0,
   output logic [7:0]         out_1,
   output logic [7:0]         out_2,
   output logic [7:0]         out_3,
   output logic [PHASE_W-1:0] out_phase,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last
);

   localparam logic [CNT_W-1:0]   LAST_WIN = CNT_W'(LINE_W - 1);
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(LINE_W);
   localparam logic [PHASE_W-1:0] LAST_PH  = PHASE_W'(SCALE - 1);
`ifdef BICUBIC_MIRROR_EDGE_EN
   // Window index whose successor is the first one needing a right pad.
   localparam logic [CNT_W-1:0]   PAD1_WIN = CNT_W'(LINE_W - 3);
`endif

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_EMIT = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [7:0]         r_w0;
   logic [7:0]         r_w1;
   logic [7:0]         r_w2;
   logic [7:0]         r_w3;
   logic [CNT_W-1:0]   r_pix_cnt;
   logic [CNT_W-1:0]   r_win_i;
   logic [PHASE_W-1:0] r_phase;
   logic               r_in_ready;
   logic               r_out_valid;

   logic               w_in_xfer;
   logic               w_out_xfer;
   logic               w_last_ph;
   logic               w_last_win;
   logic [7:0]         w_pad;

   assign w_in_xfer  = in_valid & r_in_ready;
   assign w_out_xfer = r_out_valid & out_ready;
   assign w_last_ph  = (r_phase == LAST_PH);
   assign w_last_win = (r_win_i == LAST_WIN);

`ifdef BICUBIC_MIRROR_EDGE_EN
   // p[W] = p[W-2] sits in w2 before the first padded shift;
   // p[W+1] = p[W-3] sits in w0 before the second.
   assign w_pad = (r_win_i == PAD1_WIN) ? r_w2 : r_w0;
`else
   assign w_pad = r_w3;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FILL: begin
            if (w_in_xfer && (r_pix_cnt == CNT_W'(2))) w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            if (w_out_xfer && w_last_ph) begin
               if (w_last_win)                w_state_nxt = S_FILL;
               else if (r_pix_cnt < FULL_CNT) w_state_nxt = S_WAIT;
               else                           w_state_nxt = S_EMIT;
            end
         end
         S_WAIT: begin
            if (w_in_xfer) w_state_nxt = S_EMIT;
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_FILL;
         r_w0        <= '0;
         r_w1        <= '0;
         r_w2        <= '0;
         r_w3        <= '0;
         r_pix_cnt   <= '0;
         r_win_i     <= '0;
         r_phase     <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         // Handshake flags are registered from the next state so that both
         // read 0 while reset is held and never overlap afterwards.
         r_in_ready  <= (w_state_nxt != S_EMIT);
         r_out_valid <= (w_state_nxt == S_EMIT);
         case (r_state)
            S_FILL: begin
               if (w_in_xfer) begin
                  r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                  if (r_pix_cnt == '0) begin
                     r_w0 <= in_pix;
                     r_w1 <= in_pix;
                  end else if (r_pix_cnt == CNT_W'(1)) begin
                     r_w2 <= in_pix;
`ifdef BICUBIC_MIRROR_EDGE_EN
                     r_w0 <= in_pix;
`endif
                  end else begin
                     r_w3    <= in_pix;
                     r_win_i <= '0;
                     r_phase <= '0;
                  end
               end
            end
            S_EMIT: begin
               if (w_out_xfer) begin
                  if (!w_last_ph) begin
                     r_phase <= r_phase + PHASE_W'(1);
                  end else if (w_last_win) begin
                     r_pix_cnt <= '0;
                     r_win_i   <= '0;
                     r_phase   <= '0;
                  end else if (r_pix_cnt == FULL_CNT) begin
                     // Row fully received: slide in a pad with no bubble.
                     r_w0    <= r_w1;
                     r_w1    <= r_w2;
                     r_w2    <= r_w3;
                     r_w3    <= w_pad;
                     r_win_i <= r_win_i + CNT_W'(1);
                     r_phase <= '0;
                  end
               end
            end
            S_WAIT: begin
               if (w_in_xfer) begin
                  r_w0      <= r_w1;
                  r_w1      <= r_w2;
                  r_w2      <= r_w3;
                  r_w3      <= in_pix;
                  r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                  r_win_i   <= r_win_i + CNT_W'(1);
                  r_phase   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_0     = r_w0;
   assign out_1     = r_w1;
   assign out_2     = r_w2;
   assign out_3     = r_w3;
   assign out_phase = r_phase;
   assign out_last  = r_out_valid & w_last_win & w_last_ph;

endmodule

// File: tb/tb_bicubic_window_gen.sv
// Testbench for bicubic_window_gen: a queue of expected beats, computed
// directly from the padded-row definition, is checked beat by beat.
module tb_bicubic_window_gen;
   localparam int LW = 64;
   localparam int SC = 4;
   localparam int NB = LW * SC;

   typedef logic [7:0] row_t [LW];
   typedef struct packed {
      logic [7:0] t0;
      logic [7:0] t1;
      logic [7:0] t2;
      logic [7:0] t3;
      logic [1:0] ph;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_pix = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_0, out_1, out_2, out_3;
   logic [1:0] out_phase;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_last;

   always #5 clk = ~clk;

   bicubic_window_gen #(.LINE_W(LW), .SCALE(SC), .PHASE_W(2), .CNT_W(7)) dut (
      .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid),
      .in_ready(in_ready), .out_0(out_0), .out_1(out_1), .out_2(out_2),
      .out_3(out_3), .out_phase(out_phase), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last));

   beat_t       exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          ordy_mode = 0;
   int          row_beats = 0;
   int          last_cnt = 0;
   logic        give_up = 1'b0;
   logic [31:0] cap [NB];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Padded pixel access: index outside 0..LW-1 is folded per padding rule.
   function automatic logic [7:0] pix_at(input row_t r, input int k);
`ifdef BICUBIC_MIRROR_EDGE_EN
      if (k < 0)   return r[-k];
      if (k >= LW) return r[2*LW - 2 - k];
`else
      if (k < 0)   return r[0];
      if (k >= LW) return r[LW-1];
`endif
      return r[k];
   endfunction

   function automatic logic [31:0] win_of(input row_t r, input int i);
      return {pix_at(r, i-1), pix_at(r, i), pix_at(r, i+1), pix_at(r, i+2)};
   endfunction

   task automatic push_row(input row_t r);
      beat_t b;
      for (int i = 0; i < LW; i++)
         for (int ph = 0; ph < SC; ph++) begin
            {b.t0, b.t1, b.t2, b.t3} = win_of(r, i);
            b.ph   = ph[1:0];
            b.last = (i == LW-1) && (ph == SC-1);
            exp_q.push_back(b);
         end
   endtask

   task automatic send_pix(input logic [7:0] p);
      int t = 0;
      if (give_up) return;
      in_pix = p;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 3000);
      if (!in_ready) begin
         total++; bad++; give_up = 1'b1;
         $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles want 1", t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_pix = 8'($urandom);
   endtask

   task automatic send_row(input row_t r, input int gmin, input int gmax);
      for (int k = 0; k < LW; k++) begin
         send_pix(r[k]);
         repeat ($urandom_range(gmin, gmax)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() > 0 && t < 5000 && !give_up) begin
         @(posedge clk); t++;
      end
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: got %0d beats still pending want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // out_ready driver
   initial forever begin
      @(posedge clk); #1;
      case (ordy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Compare process: every negedge
   initial begin
      beat_t cur, e, prev_b;
      logic  prev_stall, chk_ir;
      prev_stall = 1'b0;
      chk_ir = 1'b0;
      prev_b = '0;
      forever begin
         @(negedge clk);
         cur = {out_0, out_1, out_2, out_3, out_phase, out_last};
         if (!rst) begin
            prev_stall = 1'b0;
            chk_ir = 1'b0;
            check("reset_outputs", {cur, out_valid, in_ready}, 64'd0);
         end else begin
            check("ready_valid_excl", {63'd0, in_ready & out_valid}, 64'd0);
            if (chk_ir) begin
               check("in_ready_after_last", {63'd0, in_ready}, 64'd1);
               chk_ir = 1'b0;
            end
            if (prev_stall) check("stall_hold", {out_valid, cur}, {1'b1, prev_b});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL extra_beat: got beat %h want none", cur);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", 64'(cur), 64'(e));
                  cap[row_beats % NB] = cur[34:3];
                  row_beats++;
                  if (cur.last) last_cnt++;
                  if (e.last) chk_ir = 1'b1;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_b = cur;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want completion");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      row_t r, r2;
      logic [31:0] lit_first, lit_w62, lit_w63, lit_fresh, lit_pin;
`ifdef BICUBIC_MIRROR_EDGE_EN
      lit_first = 32'h01000102; lit_w62 = 32'h3d3e3f3e; lit_w63 = 32'h3e3f3e3d;
      lit_fresh = 32'h65646566; lit_pin = 32'h140a141e;
`else
      lit_first = 32'h00000102; lit_w62 = 32'h3d3e3f3f; lit_w63 = 32'h3e3f3f3f;
      lit_fresh = 32'h64646566; lit_pin = 32'h0a0a141e;
`endif
      // Model pins: row 10,20,30,... first window
      for (int k = 0; k < LW; k++) r[k] = 8'((10 * (k + 1)) & 255);
      check("model_pin_first", 64'(win_of(r, 0)), 64'(lit_pin));

      // Reset and release
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("in_ready_after_release", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;

      // Row 0..63, out_ready held high
      for (int k = 0; k < LW; k++) r[k] = 8'(k);
      ordy_mode = 0; row_beats = 0; last_cnt = 0;
      push_row(r); send_row(r, 0, 0); drain();
      check("row1_beats", 64'(row_beats), 64'(NB));
      check("row1_last_cnt", 64'(last_cnt), 64'd1);
      check("row1_first", 64'(cap[0]), 64'(lit_first));
      check("row1_win62", 64'(cap[62*SC]), 64'(lit_w62));
      check("row1_win63", 64'(cap[63*SC + 3]), 64'(lit_w63));

      // Same row, out_ready toggling
      ordy_mode = 1; row_beats = 0; last_cnt = 0;
      push_row(r); send_row(r, 0, 0); drain();
      check("toggle_beats", 64'(row_beats), 64'(NB));
      check("toggle_win62", 64'(cap[62*SC + 1]), 64'(lit_w62));

      // in_valid idle 5 cycles between pixels
      ordy_mode = 0; row_beats = 0; last_cnt = 0;
      push_row(r); send_row(r, 5, 5); drain();
      check("gap_beats", 64'(row_beats), 64'(NB));
      check("gap_last_cnt", 64'(last_cnt), 64'd1);

      // Reset mid-row after 100 beats
      ordy_mode = 2; row_beats = 0;
      push_row(r);
      for (int k = 0; k < LW; k++) begin
         if (row_beats >= 100 || give_up) break;
         send_pix(r[k]);
      end
      for (int t = 0; t < 2000 && row_beats < 100; t++) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      ordy_mode = 0; row_beats = 0; last_cnt = 0;
      for (int k = 0; k < LW; k++) r2[k] = 8'(100 + k);
      push_row(r2); send_row(r2, 0, 0); drain();
      check("fresh_first", 64'(cap[0]), 64'(lit_fresh));
      check("fresh_beats", 64'(row_beats), 64'(NB));

      // Two back-to-back random rows
      for (int k = 0; k < LW; k++) begin r[k] = 8'($urandom); r2[k] = 8'($urandom); end
      row_beats = 0; last_cnt = 0;
      push_row(r); push_row(r2);
      send_row(r, 0, 0); send_row(r2, 0, 0); drain();
      check("b2b_beats", 64'(row_beats), 64'(2*NB));
      check("b2b_last_cnt", 64'(last_cnt), 64'd2);

      // Random rows, random stalls and gaps
      ordy_mode = 2;
      for (int n = 0; n < 3; n++) begin
         for (int k = 0; k < LW; k++) r[k] = 8'($urandom);
         row_beats = 0; last_cnt = 0;
         push_row(r); send_row(r, 0, 3); drain();
         check("rand_last_cnt", 64'(last_cnt), 64'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
